// File: rtl/pipe_hazard_ctrl.sv
// Purpose: pipeline hazard controller - merges per-stage stall requests, sequences
//          multi-cycle EX ops, issues flush/redirect, plus stall watchdog and perf counter.
// Latency: stall/flush/new_pc/mc_busy/mc_done are combinational from inputs and FSM state;
//          stall_timeout and perf_stall_cnt are registered (visible the cycle after the event).
// Backpressure: none accepted; this block only produces the stall bus, it never waits.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   stallreq[NSTAGE]    bit j = stall request from stage j+1
//   mc_start/mc_cycles  start a multi-cycle EX op of length mc_cycles (pulse)
//   flush_req/flush_pc_in  flush the pipe and redirect to flush_pc_in
//   stall[NSTAGE+1]     stall bus, bit 0 = PC, bit k = stage k
//   flush/new_pc        flush all stages, redirect PC valid with flush
//   mc_busy/mc_done     mc op stalling this cycle / one-cycle result-valid pulse
//   stall_timeout       sticky watchdog flag
//   perf_stall_cnt      saturating count of cycles with stall[0]=1

module pipe_hazard_ctrl #(
  parameter int NSTAGE      = 5,
  parameter int EX_STAGE    = 3,
  parameter int CNT_W       = 6,
  parameter int WDOG_CYCLES = 256,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stallreq,
  input  logic              mc_start,
  input  logic [CNT_W-1:0]  mc_cycles,
  input  logic              flush_req,
  input  logic [31:0]       flush_pc_in,
  output logic [NSTAGE:0]   stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              mc_busy,
  output logic              mc_done,
  output logic              stall_timeout,
  output logic [PERF_W-1:0] perf_stall_cnt
);

  // Watchdog counter only needs to reach WDOG_CYCLES, where it saturates.
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WDOG_CYCLES);
  localparam logic [WD_W-1:0] WD_TRIP = WD_W'(WDOG_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mc_state_e;

  mc_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              timeout_q, timeout_d;
  logic [PERF_W-1:0] perf_q, perf_d;

  logic              mc_accept;
  logic              mc_stall;
  logic [NSTAGE:0]   req_mask;
  logic [NSTAGE:0]   mc_mask;
  logic [NSTAGE:0]   stall_raw;
  logic              stall_any;

  // ---------------------------------------------------------------------------
  // Stall request merge: a request from stage k freezes stages k..1 and the PC.
  // Walking from the top stage down, the running OR of requests at or above a
  // bit position tells whether that position must be frozen.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic acc;
    acc      = 1'b0;
    req_mask = '0;
    for (int j = NSTAGE - 1; j >= 0; j--) begin
      acc           = acc | stallreq[j];
      req_mask[j+1] = acc;
    end
    req_mask[0] = acc;
  end

  // ---------------------------------------------------------------------------
  // Multi-cycle op sequencer.
  // The accept cycle itself is the first stall cycle, so an op of length N
  // leaves BUSY after N-1 further cycles and the release (DONE) lands on t+N.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mc_stall  = 1'b0;
    // A start is only taken while not busy; a flush in the same cycle wins.
    mc_accept = (state_q != S_BUSY) && mc_start && !flush_req;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (mc_accept) begin
          mc_stall = (mc_cycles != '0);
          if (mc_cycles >= CNT_W'(2)) begin
            cnt_d   = mc_cycles - CNT_W'(1);
            state_d = S_BUSY;
          end else begin
            // N=1 stalls only in the accept cycle, N=0 not at all.
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        mc_stall = 1'b1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A flush kills any op in flight without a done pulse.
    if (flush_req) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Multi-cycle ops stall EX and everything upstream of it.
  always_comb begin
    mc_mask = '0;
    for (int i = 0; i <= NSTAGE; i++) begin
      mc_mask[i] = mc_stall && (i <= EX_STAGE);
    end
  end

  assign stall_raw = req_mask | mc_mask;

  // ---------------------------------------------------------------------------
  // Outputs: reset and flush both suppress stalling; flush has top priority.
  // mc_done is not masked by flush so a result completing in a flush cycle is
  // still reported.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall   = '0;
    flush   = 1'b0;
    new_pc  = '0;
    mc_busy = 1'b0;
    mc_done = 1'b0;
    if (!rst) begin
      flush   = flush_req;
      new_pc  = flush_req ? flush_pc_in : 32'h0;
      stall   = flush_req ? '0 : stall_raw;
      mc_busy = mc_stall && !flush_req;
      mc_done = (state_q == S_DONE);
    end
  end

  assign stall_any = (stall != '0);

  // ---------------------------------------------------------------------------
  // Watchdog: counts consecutive stall cycles; the flag is set on the cycle
  // that completes the WDOG_CYCLES-th one and stays set until reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    if (stall_any) begin
      if (wd_cnt_q != WD_MAX) begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
      end
      if (wd_cnt_q == WD_TRIP) begin
        timeout_d = 1'b1;
      end
    end else begin
      wd_cnt_d = '0;
    end
  end

  // Saturating stall-cycle counter, keyed on the PC stall bit.
  always_comb begin
    perf_d = perf_q;
    if (stall[0] && (perf_q != {PERF_W{1'b1}})) begin
      perf_d = perf_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
      perf_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
      perf_q    <= perf_d;
    end
  end

  assign stall_timeout  = timeout_q;
  assign perf_stall_cnt = perf_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (NSTAGE=5, EX_STAGE=3, WDOG_CYCLES=8, PERF_W=4).
// Each step drives one cycle of inputs and queues the expected outputs; a
// negedge checker pops and compares them.

module tb_pipe_hazard_ctrl;

  logic        clk = 1'b1;
  logic        rst;
  logic [4:0]  stallreq;
  logic        mc_start;
  logic [5:0]  mc_cycles;
  logic        flush_req;
  logic [31:0] flush_pc_in;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mc_busy;
  logic        mc_done;
  logic        stall_timeout;
  logic [3:0]  perf_stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .NSTAGE(5), .EX_STAGE(3), .CNT_W(6), .WDOG_CYCLES(8), .PERF_W(4)
  ) dut (
    .clk(clk), .rst(rst), .stallreq(stallreq), .mc_start(mc_start),
    .mc_cycles(mc_cycles), .flush_req(flush_req), .flush_pc_in(flush_pc_in),
    .stall(stall), .flush(flush), .new_pc(new_pc), .mc_busy(mc_busy),
    .mc_done(mc_done), .stall_timeout(stall_timeout), .perf_stall_cnt(perf_stall_cnt)
  );

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        busy;
    logic        done;
    logic        to;
    logic [3:0]  perf;
    logic        regs_known;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Expected registered state, derived from the expected stall bus.
  int   m_wd    = 0;
  int   m_to    = 0;
  int   m_perf  = 0;
  bit   m_known = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("stall",   32'(stall),   32'(e.stall));
      chk("flush",   32'(flush),   32'(e.flush));
      chk("new_pc",  new_pc,       e.pc);
      chk("mc_busy", 32'(mc_busy), 32'(e.busy));
      chk("mc_done", 32'(mc_done), 32'(e.done));
      if (e.regs_known) begin
        chk("stall_timeout",  32'(stall_timeout),  32'(e.to));
        chk("perf_stall_cnt", 32'(perf_stall_cnt), 32'(e.perf));
      end
    end
  end

  task automatic step(input logic r, input logic [4:0] sr, input logic ms,
                      input logic [5:0] mn, input logic fr, input logic [31:0] fpc,
                      input logic [5:0] e_stall, input logic e_busy, input logic e_done);
    exp_t e;
    rst         = r;
    stallreq    = sr;
    mc_start    = ms;
    mc_cycles   = mn;
    flush_req   = fr;
    flush_pc_in = fpc;
    e.stall      = e_stall;
    e.flush      = fr & ~r;
    e.pc         = (fr & ~r) ? fpc : 32'h0;
    e.busy       = e_busy;
    e.done       = e_done;
    e.to         = m_to[0];
    e.perf       = m_perf[3:0];
    e.regs_known = m_known;
    sb.push_back(e);
    @(posedge clk);
    if (r) begin
      m_wd = 0; m_to = 0; m_perf = 0; m_known = 1'b1;
    end else begin
      if (e_stall != 6'b0) begin
        if (m_wd == 7) m_to = 1;
        if (m_wd < 8) m_wd++;
      end else begin
        m_wd = 0;
      end
      if (e_stall[0] && m_perf < 15) m_perf++;
    end
    #1;
  endtask

  task automatic idle(input logic [5:0] e_stall, input logic e_busy, input logic e_done);
    step(1'b0, 5'b0, 1'b0, 6'd0, 1'b0, 32'h0, e_stall, e_busy, e_done);
  endtask

  task automatic mc(input logic [5:0] n, input logic [5:0] e_stall, input logic e_busy,
                    input logic e_done);
    step(1'b0, 5'b0, 1'b1, n, 1'b0, 32'h0, e_stall, e_busy, e_done);
  endtask

  initial begin
    // Reset; outputs gated even with a request present.
    step(1'b1, 5'b0,     1'b0, 6'd0, 1'b0, 32'h0, 6'b0, 1'b0, 1'b0);
    step(1'b1, 5'b00010, 1'b1, 6'd4, 1'b1, 32'h1234, 6'b0, 1'b0, 1'b0);

    // Stall merge patterns
    step(1'b0, 5'b00010, 1'b0, 6'd0, 1'b0, 32'h0, 6'b000111, 1'b0, 1'b0);
    step(1'b0, 5'b00110, 1'b0, 6'd0, 1'b0, 32'h0, 6'b001111, 1'b0, 1'b0);
    step(1'b0, 5'b10000, 1'b0, 6'd0, 1'b0, 32'h0, 6'b111111, 1'b0, 1'b0);
    step(1'b0, 5'b00001, 1'b0, 6'd0, 1'b0, 32'h0, 6'b000011, 1'b0, 1'b0);
    idle(6'b0, 1'b0, 1'b0);

    // N=4: four stall cycles, done on the fifth
    mc(6'd4, 6'b001111, 1'b1, 1'b0);
    repeat (3) idle(6'b001111, 1'b1, 1'b0);
    idle(6'b0, 1'b0, 1'b1);
    idle(6'b0, 1'b0, 1'b0);

    // Flush mid-op: stall suppressed, op aborted, no done pulse
    mc(6'd4, 6'b001111, 1'b1, 1'b0);
    idle(6'b001111, 1'b1, 1'b0);
    step(1'b0, 5'b00010, 1'b0, 6'd0, 1'b1, 32'hBFC00380, 6'b0, 1'b0, 1'b0);
    idle(6'b0, 1'b0, 1'b0);
    idle(6'b0, 1'b0, 1'b0);

    // N=1 and N=0
    mc(6'd1, 6'b001111, 1'b1, 1'b0);
    idle(6'b0, 1'b0, 1'b1);
    idle(6'b0, 1'b0, 1'b0);
    mc(6'd0, 6'b0, 1'b0, 1'b0);
    idle(6'b0, 1'b0, 1'b1);
    idle(6'b0, 1'b0, 1'b0);

    // mc_start during BUSY ignored; request OR'd with mc mask
    mc(6'd3, 6'b001111, 1'b1, 1'b0);
    mc(6'd6, 6'b001111, 1'b1, 1'b0);
    step(1'b0, 5'b10000, 1'b0, 6'd0, 1'b0, 32'h0, 6'b111111, 1'b1, 1'b0);
    idle(6'b0, 1'b0, 1'b1);
    idle(6'b0, 1'b0, 1'b0);

    // New op accepted in the DONE cycle
    mc(6'd2, 6'b001111, 1'b1, 1'b0);
    idle(6'b001111, 1'b1, 1'b0);
    mc(6'd1, 6'b001111, 1'b1, 1'b1);
    idle(6'b0, 1'b0, 1'b1);
    idle(6'b0, 1'b0, 1'b0);

    // Flush in DONE cycle still shows done; flush with same-cycle start ignores the start
    mc(6'd1, 6'b001111, 1'b1, 1'b0);
    step(1'b0, 5'b0, 1'b0, 6'd0, 1'b1, 32'h00001000, 6'b0, 1'b0, 1'b1);
    idle(6'b0, 1'b0, 1'b0);
    step(1'b0, 5'b0, 1'b1, 6'd3, 1'b1, 32'h80000000, 6'b0, 1'b0, 1'b0);
    idle(6'b0, 1'b0, 1'b0);
    idle(6'b0, 1'b0, 1'b0);

    // Watchdog: 10 consecutive stall cycles, flag stays after release
    repeat (10) step(1'b0, 5'b00010, 1'b0, 6'd0, 1'b0, 32'h0, 6'b000111, 1'b0, 1'b0);
    repeat (3) idle(6'b0, 1'b0, 1'b0);

    // Reset clears counters and flag; then reset mid-BUSY aborts silently
    step(1'b1, 5'b0, 1'b0, 6'd0, 1'b0, 32'h0, 6'b0, 1'b0, 1'b0);
    mc(6'd20, 6'b001111, 1'b1, 1'b0);
    repeat (4) idle(6'b001111, 1'b1, 1'b0);
    step(1'b1, 5'b0, 1'b0, 6'd0, 1'b0, 32'h0, 6'b0, 1'b0, 1'b0);
    repeat (4) idle(6'b0, 1'b0, 1'b0);

    // Bounded drain of the scoreboard
    repeat (4) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
